// File: rtl/binary_activation_threshold_pipe_if.sv
// Stream bundle for the binary activation threshold stage: threshold load port,
// input tile stream, output activation stream and the loaded status flag.
interface binary_activation_threshold_pipe_if #(
    parameter int unsigned IN_WIDTH     = 8,
    parameter int unsigned ROWS         = 4,
    parameter int unsigned COLUMNS      = 5,
    parameter int unsigned THRESH_WIDTH = IN_WIDTH
);
    // Threshold load stream, column 0 first
    logic [THRESH_WIDTH-1:0]                thresh_in;
    logic                                   thresh_in_valid;
    logic                                   thresh_in_ready;
    logic                                   thresh_reload;

    // Input tile of signed sums, element r*COLUMNS+c is row r, column c
    logic [ROWS*COLUMNS-1:0][IN_WIDTH-1:0]  data_in;
    logic                                   data_in_valid;
    logic                                   data_in_ready;

    // Output tile of 1-bit activations, same element ordering as data_in
    logic [ROWS*COLUMNS-1:0]                data_out;
    logic                                   data_out_valid;
    logic                                   data_out_ready;

    logic                                   loaded;

    modport slave (
        input  thresh_in, thresh_in_valid, thresh_reload,
        input  data_in, data_in_valid, data_out_ready,
        output thresh_in_ready, data_in_ready, data_out, data_out_valid, loaded
    );

    modport master (
        output thresh_in, thresh_in_valid, thresh_reload,
        output data_in, data_in_valid, data_out_ready,
        input  thresh_in_ready, data_in_ready, data_out, data_out_valid, loaded
    );
endinterface

// File: rtl/binary_activation_threshold_pipe.sv
// Thresholds each tile of signed popcount sums per column into 1-bit activations.
// Per-column thresholds are loaded serially and may be reloaded at runtime; a
// reload first drains the output register so every tile keeps the thresholds
// it was accepted under.
module binary_activation_threshold_pipe #(
    parameter int unsigned IN_WIDTH     = 8,
    parameter int unsigned ROWS         = 4,
    parameter int unsigned COLUMNS      = 5,
    parameter int unsigned THRESH_WIDTH = IN_WIDTH
) (
    input logic                               clk,
    input logic                               rst,
    binary_activation_threshold_pipe_if.slave bus
);
    localparam int unsigned N     = ROWS * COLUMNS;
    localparam int unsigned CmpW  = (IN_WIDTH > THRESH_WIDTH) ? IN_WIDTH : THRESH_WIDTH;
    localparam int unsigned CntW  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam logic [CntW-1:0] LastCol = CntW'(COLUMNS - 1);

    typedef enum logic [1:0] {StLoad, StRun, StDrain} state_t;

    state_t                         state;
    logic [CntW-1:0]                cnt;
    logic signed [THRESH_WIDTH-1:0] thr [COLUMNS];
    logic [N-1:0]                   out_bits;
    logic                           out_valid;
    logic [N-1:0]                   act;
    logic                           thresh_hs;
    logic                           in_hs;
    logic                           in_ready;

    assign in_ready  = (state == StRun) && (!out_valid || bus.data_out_ready);
    assign in_hs     = in_ready && bus.data_in_valid;
    assign thresh_hs = (state == StLoad) && bus.thresh_in_valid;

    assign bus.thresh_in_ready = (state == StLoad);
    assign bus.data_in_ready   = in_ready;
    assign bus.loaded          = (state == StRun);
    assign bus.data_out        = out_bits;
    assign bus.data_out_valid  = out_valid;

    // Per-element signed compare, both operands sign-extended to the wider width
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLUMNS; c++) begin : g_col
            logic signed [CmpW-1:0] lhs;
            logic signed [CmpW-1:0] rhs;
            assign lhs = CmpW'($signed(bus.data_in[r*COLUMNS+c]));
            assign rhs = CmpW'(thr[c]);
            assign act[r*COLUMNS+c] = (lhs >= rhs);
        end
    end

    // Control FSM: serial threshold load, run, and drain before a reload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StLoad;
            cnt   <= '0;
            for (int i = 0; i < COLUMNS; i++) begin
                thr[i] <= '0;
            end
        end else begin
            case (state)
                StLoad: begin
                    if (thresh_hs) begin
                        thr[cnt] <= $signed(bus.thresh_in);
                        if (cnt == LastCol) begin
                            cnt   <= '0;
                            state <= StRun;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (bus.thresh_reload) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    // Leave once the register is empty or is emptied at this edge
                    if (!out_valid || bus.data_out_ready) begin
                        state <= StLoad;
                    end
                end
                default: state <= StLoad;
            endcase
        end
    end

    // Output register: capture on accept, clear on handshake, hold under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_bits  <= '0;
            out_valid <= 1'b0;
        end else if (in_hs) begin
            out_bits  <= act;
            out_valid <= 1'b1;
        end else if (bus.data_out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_binary_activation_threshold_pipe.sv
// Directed bench for binary_activation_threshold_pipe: load, threshold, throughput,
// backpressure, reload-with-drain, asynchronous reset and boundary values.
module tb_binary_activation_threshold_pipe;
    localparam int unsigned IW = 8;
    localparam int unsigned R  = 4;
    localparam int unsigned C  = 5;
    localparam int unsigned N  = R * C;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    binary_activation_threshold_pipe_if #(
        .IN_WIDTH(IW), .ROWS(R), .COLUMNS(C), .THRESH_WIDTH(IW)
    ) bus ();

    binary_activation_threshold_pipe #(
        .IN_WIDTH(IW), .ROWS(R), .COLUMNS(C), .THRESH_WIDTH(IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int thr_m [C];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_row(input int r, input int a0, input int a1, input int a2,
                           input int a3, input int a4);
        bus.data_in[r*C+0] = 8'(a0);
        bus.data_in[r*C+1] = 8'(a1);
        bus.data_in[r*C+2] = 8'(a2);
        bus.data_in[r*C+3] = 8'(a3);
        bus.data_in[r*C+4] = 8'(a4);
    endtask

    // Row 0 gets a*, rows 1..R-1 get b*
    task automatic set_tile(input int a0, input int a1, input int a2, input int a3, input int a4,
                            input int b0, input int b1, input int b2, input int b3, input int b4);
        set_row(0, a0, a1, a2, a3, a4);
        for (int r = 1; r < R; r++) set_row(r, b0, b1, b2, b3, b4);
    endtask

    task automatic set_uniform(input int v);
        for (int i = 0; i < N; i++) bus.data_in[i] = 8'(v);
    endtask

    // Expected tile when every element equals v, against the bench's threshold copy
    function automatic logic [N-1:0] exp_uni(input int v);
        logic [N-1:0] e;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                e[r*C+c] = (v >= thr_m[c]);
        return e;
    endfunction

    function automatic logic [N-1:0] tile_bits(input logic [4:0] row0, input logic [4:0] rest);
        return {rest, rest, rest, row0};
    endfunction

    task automatic load5(input int t0, input int t1, input int t2, input int t3, input int t4);
        int w [C];
        w = '{t0, t1, t2, t3, t4};
        bus.thresh_in_valid = 1'b1;
        for (int i = 0; i < C; i++) begin
            bus.thresh_in = 8'(w[i]);
            chk1("load_not_loaded", bus.loaded, 1'b0);
            chk1("load_thr_ready", bus.thresh_in_ready, 1'b1);
            step();
            thr_m[i] = w[i];
        end
        bus.thresh_in_valid = 1'b0;
    endtask

    initial begin
        rst                 = 1'b1;
        bus.thresh_in       = '0;
        bus.thresh_in_valid = 1'b0;
        bus.thresh_reload   = 1'b0;
        bus.data_in         = '0;
        bus.data_in_valid   = 1'b0;
        bus.data_out_ready  = 1'b0;
        for (int i = 0; i < C; i++) thr_m[i] = 0;

        step();
        step();
        chk1("rst_out_valid", bus.data_out_valid, 1'b0);
        chk1("rst_loaded", bus.loaded, 1'b0);
        chk1("rst_thr_ready", bus.thresh_in_ready, 1'b1);
        chk1("rst_in_ready", bus.data_in_ready, 1'b0);
        chkv("rst_data_out", bus.data_out, '0);
        rst = 1'b0;
        step();

        // Tile offered during LOAD must be ignored
        set_uniform(7);
        bus.data_in_valid = 1'b1;
        chk1("load_in_ready", bus.data_in_ready, 1'b0);
        load5(0, 1, -1, 3, -4);
        bus.data_in_valid = 1'b0;
        chk1("load_done_loaded", bus.loaded, 1'b1);
        chk1("load_done_thr_ready", bus.thresh_in_ready, 1'b0);
        chk1("load_no_output", bus.data_out_valid, 1'b0);

        // First tile, one-cycle latency
        set_tile(0, 0, -1, 3, -5, -1, 1, 0, 2, -4);
        bus.data_out_ready = 1'b1;
        bus.data_in_valid  = 1'b1;
        chk1("t1_in_ready", bus.data_in_ready, 1'b1);
        step();
        bus.data_in_valid = 1'b0;
        chk1("t1_valid", bus.data_out_valid, 1'b1);
        chkv("t1_data", bus.data_out, tile_bits(5'b01101, 5'b10110));
        step();
        chk1("t1_valid_clear", bus.data_out_valid, 1'b0);

        // Ten back-to-back tiles at full throughput
        set_uniform(-5);
        bus.data_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk1("b2b_valid", bus.data_out_valid, 1'b1);
            chkv("b2b_data", bus.data_out, exp_uni(i - 5));
            if (i < 9) set_uniform(i - 4);
        end

        // Backpressure: output held, no new accept
        set_uniform(2);
        bus.data_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("bp_in_ready", bus.data_in_ready, 1'b0);
            chk1("bp_valid", bus.data_out_valid, 1'b1);
            chkv("bp_data", bus.data_out, exp_uni(4));
            step();
        end
        bus.data_out_ready = 1'b1;
        #1;
        chk1("bp_release_ready", bus.data_in_ready, 1'b1);
        step();
        bus.data_in_valid = 1'b0;
        chkv("bp_next_data", bus.data_out, exp_uni(2));
        step();
        chk1("bp_drained", bus.data_out_valid, 1'b0);

        // Reload coincident with an accepted tile under backpressure
        bus.data_out_ready = 1'b0;
        set_tile(0, 0, -1, 3, -5, -1, 1, 0, 2, -4);
        bus.data_in_valid = 1'b1;
        bus.thresh_reload = 1'b1;
        step();
        bus.data_in_valid = 1'b0;
        bus.thresh_reload = 1'b0;
        chk1("drain_loaded", bus.loaded, 1'b0);
        chk1("drain_in_ready", bus.data_in_ready, 1'b0);
        chkv("drain_old_thr", bus.data_out, tile_bits(5'b01101, 5'b10110));
        bus.thresh_in       = 8'(-128);
        bus.thresh_in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk1("drain_thr_ready", bus.thresh_in_ready, 1'b0);
            step();
        end
        bus.thresh_in_valid = 1'b0;
        chk1("drain_hold_valid", bus.data_out_valid, 1'b1);
        bus.data_out_ready = 1'b1;
        step();
        chk1("drain_to_load", bus.thresh_in_ready, 1'b1);
        chk1("drain_out_clear", bus.data_out_valid, 1'b0);

        // Reload request during LOAD is ignored
        bus.thresh_reload = 1'b1;
        load5(5, 5, 5, 5, 5);
        bus.thresh_reload = 1'b0;
        chk1("reload_loaded", bus.loaded, 1'b1);
        set_uniform(4);
        bus.data_in_valid = 1'b1;
        step();
        chkv("new_thr_below", bus.data_out, '0);
        set_uniform(5);
        step();
        bus.data_in_valid = 1'b0;
        chkv("new_thr_equal", bus.data_out, '1);

        // Asynchronous reset while running with a valid output
        bus.data_out_ready = 1'b0;
        step();
        chk1("pre_rst_valid", bus.data_out_valid, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk1("arst_valid", bus.data_out_valid, 1'b0);
        chk1("arst_loaded", bus.loaded, 1'b0);
        chkv("arst_data", bus.data_out, '0);
        rst = 1'b0;
        for (int i = 0; i < C; i++) thr_m[i] = 0;

        // Asynchronous reset after two of five threshold words
        step();
        bus.thresh_in_valid = 1'b1;
        bus.thresh_in       = 8'(9);
        step();
        step();
        bus.thresh_in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk1("mid_rst_loaded", bus.loaded, 1'b0);
        chk1("mid_rst_thr_ready", bus.thresh_in_ready, 1'b1);
        rst = 1'b0;
        step();

        // Full reload required; boundary thresholds
        load5(-128, 127, 127, 0, 0);
        chk1("bnd_loaded", bus.loaded, 1'b1);
        set_tile(-128, 127, 126, 0, -1, 127, 127, -128, -1, 0);
        bus.data_out_ready = 1'b1;
        bus.data_in_valid  = 1'b1;
        step();
        bus.data_in_valid = 1'b0;
        chk1("bnd_valid", bus.data_out_valid, 1'b1);
        chkv("bnd_data", bus.data_out, tile_bits(5'b01011, 5'b10011));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
